// File: rtl/seg7_display_sched.sv
// Display source scheduler for the 8-digit hex display.
// It chooses between the CPU display register and NDBG live debug words and feeds the seg7 driver.
module seg7_display_sched #(
   parameter int NDBG     = 4,
   parameter int DWELL    = 100000000,
   parameter int CPU_HOLD = 200000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_we,
   input  logic [31:0]          cpu_wdata,
   input  logic [32*NDBG-1:0]   dbg_data,
   input  logic                 auto_en,
   input  logic                 step,
   input  logic                 freeze,
   output logic                 o_cs,
   output logic [31:0]          o_data,
   output logic [2:0]           o_src,
   output logic                 o_preempt
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int PW = (CPU_HOLD > 1) ? $clog2(CPU_HOLD) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [PW-1:0] HOLD_LAST  = PW'(CPU_HOLD - 1);
   localparam logic [2:0]    IDX_LAST   = 3'(NDBG);

   typedef enum logic [1:0] {
      ROTATE  = 2'd0,
      PREEMPT = 2'd1,
      FROZEN  = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [2:0]    idx, idx_nx, idx_inc;
   logic [DW-1:0] dwell_cnt, dwell_nx;
   logic [PW-1:0] pre_cnt, pre_nx;
   logic [31:0]   cpu_reg;
   logic          step_q, step_rise;
   logic [31:0]   sel;

   logic          cs_nx;
   logic [31:0]   data_nx;
   logic [2:0]    src_nx;
   logic          preempt_nx;

   assign step_rise = step & ~step_q;
   assign idx_inc   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

   // Source 0 is the CPU register; source k+1 is debug word k.
   always_comb begin
      sel = cpu_reg;
      for (int k = 0; k < NDBG; k++) begin
         if (idx == 3'(k + 1)) sel = dbg_data[32*k +: 32];
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_nx   = state;
      idx_nx     = idx;
      dwell_nx   = dwell_cnt;
      pre_nx     = pre_cnt;
      cs_nx      = 1'b0;
      data_nx    = o_data;
      src_nx     = o_src;
      preempt_nx = 1'b0;

      case (state)
         ROTATE: begin
            cs_nx   = 1'b1;
            data_nx = sel;
            src_nx  = idx;
            if (cpu_we) begin
               state_nx = PREEMPT;
               pre_nx   = '0;
            end else if (freeze) begin
               state_nx = FROZEN;
            end else if (auto_en) begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_nx = '0;
                  idx_nx   = idx_inc;
               end else begin
                  dwell_nx = dwell_cnt + 1'b1;
               end
            end else if (step_rise) begin
               idx_nx = idx_inc;
            end
         end

         PREEMPT: begin
            cs_nx      = 1'b1;
            data_nx    = cpu_reg;
            src_nx     = 3'd0;
            preempt_nx = 1'b1;
            if (cpu_we) begin
               pre_nx = '0;
            end else if (pre_cnt == HOLD_LAST) begin
               pre_nx = '0;
               if (freeze) begin
                  state_nx = FROZEN;
               end else begin
                  state_nx = ROTATE;
                  dwell_nx = '0;
               end
            end else begin
               pre_nx = pre_cnt + 1'b1;
            end
         end

         FROZEN: begin
            // Display driver keeps its last load; only the exit condition is watched.
            if (!freeze) state_nx = ROTATE;
         end

         default: begin
            state_nx = ROTATE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ROTATE;
         idx       <= 3'd0;
         dwell_cnt <= '0;
         pre_cnt   <= '0;
         cpu_reg   <= 32'd0;
         step_q    <= 1'b0;
         o_cs      <= 1'b0;
         o_data    <= 32'd0;
         o_src     <= 3'd0;
         o_preempt <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         dwell_cnt <= dwell_nx;
         pre_cnt   <= pre_nx;
         step_q    <= step;
         if (cpu_we) cpu_reg <= cpu_wdata;
         o_cs      <= cs_nx;
         o_data    <= data_nx;
         o_src     <= src_nx;
         o_preempt <= preempt_nx;
      end
   end

endmodule

// File: tb/tb_seg7_display_sched.sv
// Directed testbench for seg7_display_sched with NDBG=2, DWELL=4, CPU_HOLD=3.
module tb_seg7_display_sched;

   localparam int NDBG = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_we;
   logic [31:0] cpu_wdata;
   logic [31:0] dbg0, dbg1;
   logic [63:0] dbg_data;
   logic        auto_en, step, freeze;
   logic        o_cs;
   logic [31:0] o_data;
   logic [2:0]  o_src;
   logic        o_preempt;

   int checks = 0;
   int errors = 0;

   assign dbg_data = {dbg1, dbg0};

   seg7_display_sched #(.NDBG(NDBG), .DWELL(4), .CPU_HOLD(3)) dut (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .dbg_data(dbg_data), .auto_en(auto_en), .step(step), .freeze(freeze),
      .o_cs(o_cs), .o_data(o_data), .o_src(o_src), .o_preempt(o_preempt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset over two edges, checks the reset values, then releases just after an edge.
   task automatic reset_dut(input logic en);
      reset = 1'b1; cpu_we = 1'b0; cpu_wdata = 32'd0; step = 1'b0; freeze = 1'b0;
      auto_en = en; dbg0 = 32'h0000_1111; dbg1 = 32'h0000_2222;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_cs, o_data, o_src, o_preempt} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs: got cs=%b data=%h src=%0d pre=%b want all zero",
                  o_cs, o_data, o_src, o_preempt);
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut(1'b1);
   endtask

   // Thirteen cycles of auto rotation: four cycles per source, wrapping 2 -> 0.
   task automatic check_rotation(input string tag);
      logic [2:0]  exp_src;
      logic [31:0] exp_data;
      for (int i = 0; i < 13; i++) begin
         tick();
         exp_src  = 3'((i / 4) % 3);
         exp_data = (exp_src == 3'd0) ? 32'd0 : (exp_src == 3'd1) ? 32'h0000_1111 : 32'h0000_2222;
         checks++;
         if (o_src !== exp_src || o_data !== exp_data || o_cs !== 1'b1 || o_preempt !== 1'b0) begin
            errors++;
            $display("FAIL %s_cycle%0d: got src=%0d data=%h cs=%b pre=%b want src=%0d data=%h cs=1 pre=0",
                     tag, i, o_src, o_data, o_cs, o_preempt, exp_src, exp_data);
         end
      end
   endtask

   task automatic test_auto_rotation();
      reset_dut(1'b1);
      check_rotation("rot");
   endtask

   task automatic test_cpu_preempt();
      reset_dut(1'b1);
      repeat (5) tick();
      cpu_we = 1'b1; cpu_wdata = 32'hDEAD_BEEF;
      tick();
      cpu_we = 1'b0;
      checks++;
      if (o_preempt !== 1'b0 || o_src !== 3'd1) begin
         errors++;
         $display("FAIL pre_write_cycle: got pre=%b src=%0d want pre=0 src=1", o_preempt, o_src);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (o_preempt !== 1'b1 || o_data !== 32'hDEAD_BEEF || o_src !== 3'd0 || o_cs !== 1'b1) begin
            errors++;
            $display("FAIL pre_hold%0d: got pre=%b data=%h src=%0d cs=%b want pre=1 data=deadbeef src=0 cs=1",
                     i, o_preempt, o_data, o_src, o_cs);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (o_preempt !== 1'b0 || o_src !== 3'd1 || o_data !== 32'h0000_1111) begin
            errors++;
            $display("FAIL pre_resume%0d: got pre=%b src=%0d data=%h want pre=0 src=1 data=00001111",
                     i, o_preempt, o_src, o_data);
         end
      end
      repeat (4) tick();
      checks++;
      if (o_src !== 3'd2) begin
         errors++;
         $display("FAIL pre_next_src: got src=%0d want 2", o_src);
      end
      tick();
      checks++;
      if (o_src !== 3'd0 || o_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL pre_cpu_src: got src=%0d data=%h want src=0 data=deadbeef", o_src, o_data);
      end
   endtask

   task automatic test_manual_step();
      logic [2:0] exp_src;
      reset_dut(1'b0);
      repeat (6) tick();
      checks++;
      if (o_src !== 3'd0) begin
         errors++;
         $display("FAIL step_idle: got src=%0d want 0", o_src);
      end
      for (int i = 0; i < 3; i++) begin
         step = 1'b1; tick();
         step = 1'b0; tick();
         exp_src = 3'((i + 1) % 3);
         checks++;
         if (o_src !== exp_src) begin
            errors++;
            $display("FAIL step_pulse%0d: got src=%0d want %0d", i, o_src, exp_src);
         end
      end
      step = 1'b1;
      repeat (10) tick();
      checks++;
      if (o_src !== 3'd1) begin
         errors++;
         $display("FAIL step_held: got src=%0d want 1", o_src);
      end
      step = 1'b0;
      repeat (2) tick();
      checks++;
      if (o_src !== 3'd1 || o_data !== 32'h0000_1111) begin
         errors++;
         $display("FAIL step_release: got src=%0d data=%h want src=1 data=00001111", o_src, o_data);
      end
   endtask

   task automatic test_freeze();
      reset_dut(1'b1);
      repeat (10) tick();
      freeze = 1'b1;
      tick();
      checks++;
      if (o_cs !== 1'b1 || o_src !== 3'd2) begin
         errors++;
         $display("FAIL frz_entry: got cs=%b src=%0d want cs=1 src=2", o_cs, o_src);
      end
      dbg1 = 32'h0000_3333;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (o_cs !== 1'b0 || o_data !== 32'h0000_2222 || o_src !== 3'd2) begin
            errors++;
            $display("FAIL frz_hold%0d: got cs=%b data=%h src=%0d want cs=0 data=00002222 src=2",
                     i, o_cs, o_data, o_src);
         end
      end
      freeze = 1'b0;
      tick();
      tick();
      checks++;
      if (o_cs !== 1'b1 || o_data !== 32'h0000_3333 || o_src !== 3'd2) begin
         errors++;
         $display("FAIL frz_exit: got cs=%b data=%h src=%0d want cs=1 data=00003333 src=2",
                  o_cs, o_data, o_src);
      end
      tick();
      checks++;
      if (o_src !== 3'd2) begin
         errors++;
         $display("FAIL frz_dwell_left: got src=%0d want 2", o_src);
      end
      tick();
      checks++;
      if (o_src !== 3'd0) begin
         errors++;
         $display("FAIL frz_dwell_done: got src=%0d want 0", o_src);
      end
   endtask

   task automatic test_preempt_then_freeze();
      reset_dut(1'b1);
      repeat (2) tick();
      cpu_we = 1'b1; cpu_wdata = 32'hCAFE_F00D; freeze = 1'b1;
      tick();
      cpu_we = 1'b0;
      checks++;
      if (o_preempt !== 1'b0 || o_data !== 32'd0) begin
         errors++;
         $display("FAIL pf_write_cycle: got pre=%b data=%h want pre=0 data=0", o_preempt, o_data);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (o_preempt !== 1'b1 || o_cs !== 1'b1 || o_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL pf_hold%0d: got pre=%b cs=%b data=%h want pre=1 cs=1 data=cafef00d",
                     i, o_preempt, o_cs, o_data);
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (o_cs !== 1'b0 || o_preempt !== 1'b0 || o_data !== 32'hCAFE_F00D || o_src !== 3'd0) begin
            errors++;
            $display("FAIL pf_frozen%0d: got cs=%b pre=%b data=%h src=%0d want cs=0 pre=0 data=cafef00d src=0",
                     i, o_cs, o_preempt, o_data, o_src);
         end
      end
      freeze = 1'b0;
      repeat (2) tick();
      checks++;
      if (o_cs !== 1'b1 || o_src !== 3'd0 || o_data !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL pf_resume: got cs=%b src=%0d data=%h want cs=1 src=0 data=cafef00d",
                  o_cs, o_src, o_data);
      end
   endtask

   task automatic test_reset_mid_preempt();
      reset_dut(1'b1);
      repeat (5) tick();
      cpu_we = 1'b1; cpu_wdata = 32'h1234_5678;
      tick();
      cpu_we = 1'b0;
      tick();
      checks++;
      if (o_preempt !== 1'b1 || o_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL mid_preempt: got pre=%b data=%h want pre=1 data=12345678", o_preempt, o_data);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({o_cs, o_data, o_src, o_preempt} !== 37'd0) begin
         errors++;
         $display("FAIL async_reset: got cs=%b data=%h src=%0d pre=%b want all zero",
                  o_cs, o_data, o_src, o_preempt);
      end
      reset_dut(1'b1);
      check_rotation("post_rst");
   endtask

   initial begin
      reset = 1'b1; cpu_we = 1'b0; cpu_wdata = 32'd0; step = 1'b0; freeze = 1'b0;
      auto_en = 1'b1; dbg0 = 32'h0000_1111; dbg1 = 32'h0000_2222;
      test_reset();
      test_auto_rotation();
      test_cpu_preempt();
      test_manual_step();
      test_freeze();
      test_preempt_then_freeze();
      test_reset_mid_preempt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
